sync_fifo_th: RTL and testbench
===============================

Name: sync_fifo_th

Overview:
Parametrised synchronous FIFO with runtime-programmable almost-empty and almost-full thresholds, an occupancy count, a synchronous flush, and overflow/underflow error reporting. It succeeds the single-threshold FIFO. It supports non-power-of-two depths and adds a full-side watermark and error flags. It sits between producer and consumer blocks in one clock domain.

Parameters:
FIFO_DEPTH, 16, number of entries; any integer >= 2, power of two not required
DATA_WIDTH, 32, width of one entry in bits
ADDR_WIDTH, $clog2(FIFO_DEPTH), pointer width
CNT_WIDTH, $clog2(FIFO_DEPTH+1), width of count and thresholds; always able to hold FIFO_DEPTH

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
clr  input  1  synchronous flush
wr_en  input  1  write request
wr_data  input  DATA_WIDTH  write data
rd_en  input  1  read request
rd_data  output  DATA_WIDTH  read data, registered
rd_vld  output  1  rd_data is valid this cycle
full  output  1  cnt == FIFO_DEPTH
empty  output  1  cnt == 0
aempty_th  input  CNT_WIDTH  almost-empty threshold
aempty  output  1  cnt <= aempty_th
afull_th  input  CNT_WIDTH  almost-full threshold
afull  output  1  cnt >= afull_th
cnt  output  CNT_WIDTH  current occupancy
ovf  output  1  write attempted while full
udf  output  1  read attempted while empty

Behaviour:
- Reset (rst_n=0 at a clk edge) values: wr_ptr=0, rd_ptr=0, cnt=0, empty=1, full=0, aempty=1, afull=0, rd_vld=0, rd_data=0, ovf=0, udf=0. Memory contents are not reset. Reset overrides clr, wr_en and rd_en.
- Write acceptance: wr_acc = wr_en & ~full. Read acceptance: rd_acc = rd_en & ~empty. Both use the registered flags from the current cycle.
- Full and simultaneous read+write: the read is accepted, the write is rejected, and an ovf event occurs.
- Empty and simultaneous read+write: the write is accepted, the read is rejected, and a udf event occurs. There is no fall-through.
- Accepted write: mem[wr_ptr] <= wr_data. wr_ptr advances; at FIFO_DEPTH-1 it wraps to 0.
- Accepted read: rd_data <= mem[rd_ptr] at the same edge, and rd_vld=1 for the next cycle. rd_ptr advances with the same wrap rule.
- Without an accepted read, rd_vld=0 and rd_data holds its last value.
- Read latency: 1 cycle from rd_en high to rd_vld high.
- Count update: cnt_nxt = cnt + wr_acc - rd_acc. If both are accepted, cnt is unchanged.
- Flags are registered from cnt_nxt, so full, empty, aempty and afull always agree with cnt in the same cycle:
  - full = (cnt_nxt == FIFO_DEPTH)
  - empty = (cnt_nxt == 0)
  - aempty = (cnt_nxt <= aempty_th)
  - afull = (cnt_nxt >= afull_th)
- Thresholds are sampled live every cycle, and a change takes effect on flags at the next edge.
- Threshold edge cases:
  - aempty_th >= FIFO_DEPTH gives aempty constantly 1.
  - afull_th == 0 gives afull 1 from the first post-reset edge.
  - afull_th > FIFO_DEPTH gives afull constantly 0.
- clr=1: wr_ptr, rd_ptr and cnt go to 0 and flags take their reset values. rd_vld=0 and ovf/udf are cleared. wr_en and rd_en are ignored that cycle (no write, no read, no error event). rd_data holds its value.
- Error events: ovf_evt = wr_en & full & ~clr, and udf_evt = rd_en & empty & ~clr. How they appear on ovf/udf is set by the optional feature.
- Pointer/count invariant: (wr_ptr - rd_ptr) mod FIFO_DEPTH == cnt mod FIFO_DEPTH, at all times.

Optional Feature:
FIFO_STICKY_ERR_EN.
- Defined: ovf/udf are sticky. Each is set on the cycle after its event and held until clr or reset.
- Undefined: ovf/udf are 1-cycle pulses, registered one cycle after each event. Consecutive events give a continuous high level.

Test Plan:
- Reset, DEPTH=16, aempty_th=2, afull_th=14: after rst_n rises, cnt=0, empty=1, aempty=1, afull=0, full=0, rd_vld=0, ovf=0, udf=0.
- Fill, DEPTH=16: write 16 words 0x1000..0x100F back-to-back.
  - cnt steps 1..16.
  - aempty drops when cnt=3.
  - afull rises when cnt=14.
  - full=1 at cnt=16.
  - A 17th write is dropped and ovf pulses (or sticks with FIFO_STICKY_ERR_EN); cnt stays 16.
- Drain: 16 back-to-back reads.
  - rd_data=0x1000..0x100F in order, each with rd_vld one cycle after rd_en.
  - empty=1 after the 16th read.
  - A 17th read gives udf=1, rd_vld=0 and rd_data held at 0x100F.
- Non-power-of-two wrap, DEPTH=12: 30 writes interleaved with reads, keeping cnt between 3 and 9. All data returns in order across pointer wraps 11->0, and the invariant holds every cycle.
- Simultaneous read+write:
  - cnt=5: cnt stays 5 and data order is preserved.
  - At full=1: read accepted, write dropped, ovf=1, cnt=15.
  - At empty=1: write accepted, udf=1, cnt=1.
- Flush: at cnt=7, assert clr together with wr_en and rd_en. Next cycle cnt=0, empty=1, rd_vld=0, ovf=0, udf=0. The next write/read pair returns the new data, not stale data.

Source files
------------

// File: rtl/sync_fifo_th.sv
// ---------------------------------------------------------------------------
// sync_fifo_th
//   Single-clock FIFO with runtime-programmable almost-empty / almost-full
//   watermarks, an occupancy count, a synchronous flush and overflow /
//   underflow error reporting. Any depth >= 2 is supported; the pointers wrap
//   explicitly at FIFO_DEPTH-1, so the depth does not have to be a power of two.
//
//   Optional feature macro: FIFO_STICKY_ERR_EN
//     defined   : ovf/udf are sticky, set the cycle after their event and held
//                 until clr or reset.
//     undefined : ovf/udf are one-cycle pulses, one cycle after each event.
//
// Handshake: a write is accepted when wr_en=1 and full=0; a read is accepted
//   when rd_en=1 and empty=0. Both decisions use the registered flags of the
//   current cycle. An accepted read returns rd_data with rd_vld=1 in the next
//   cycle. There is no fall-through from an empty FIFO.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset (overrides everything)
//   clr        synchronous flush
//   wr_en      write request            wr_data  write data
//   rd_en      read request             rd_data  registered read data
//   rd_vld     rd_data valid this cycle
//   full       cnt == FIFO_DEPTH        empty    cnt == 0
//   aempty_th  almost-empty threshold   aempty   cnt <= aempty_th
//   afull_th   almost-full threshold    afull    cnt >= afull_th
//   cnt        current occupancy
//   ovf        write attempted while full
//   udf        read attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_th #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_vld,
  output logic                  full,
  output logic                  empty,
  input  logic [CNT_WIDTH-1:0]  aempty_th,
  output logic                  aempty,
  input  logic [CNT_WIDTH-1:0]  afull_th,
  output logic                  afull,
  output logic [CNT_WIDTH-1:0]  cnt,
  output logic                  ovf,
  output logic                  udf
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  aempty_q, aempty_d;
  logic                  afull_q, afull_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic wr_acc, rd_acc, mem_we;
  logic ovf_evt, udf_evt;

  always_comb begin
    wr_acc  = wr_en & ~full_q;
    rd_acc  = rd_en & ~empty_q;
    ovf_evt = wr_en & full_q & ~clr;
    udf_evt = rd_en & empty_q & ~clr;
    mem_we  = wr_acc & ~clr;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    empty_d   = empty_q;
    aempty_d  = aempty_q;
    afull_d   = afull_q;
    rd_vld_d  = 1'b0;
    rd_data_d = rd_data_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;

    if (clr) begin
      // Flush: flags return to their reset values regardless of thresholds;
      // rd_data keeps its last value.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      full_d   = 1'b0;
      empty_d  = 1'b1;
      aempty_d = 1'b1;
      afull_d  = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr_d  = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
        rd_vld_d  = 1'b1;
        rd_data_d = mem_q[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
        2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
        default: cnt_d = cnt_q;
      endcase
      // Flags are derived from the next count so they always match cnt.
      full_d   = (cnt_d == DEPTH_CNT);
      empty_d  = (cnt_d == '0);
      aempty_d = (cnt_d <= aempty_th);
      afull_d  = (cnt_d >= afull_th);
`ifdef FIFO_STICKY_ERR_EN
      ovf_d = ovf_q | ovf_evt;
      udf_d = udf_q | udf_evt;
`else
      ovf_d = ovf_evt;
      udf_d = udf_evt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      aempty_q  <= 1'b1;
      afull_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      aempty_q  <= aempty_d;
      afull_q   <= afull_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_vld  = rd_vld_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign aempty  = aempty_q;
  assign afull   = afull_q;
  assign cnt     = cnt_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;

endmodule

// File: tb/tb_sync_fifo_th.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_th
//   Bench for sync_fifo_th. Instance u_a (depth 16) runs a vector table for
//   fill/drain plus hand-written corner sequences; instance u_b (depth 12)
//   runs randomized traffic against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_sync_fifo_th;

`ifdef FIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  localparam int DA = 16;
  localparam int DB = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (depth 16) ----------------
  logic        a_clr = 0, a_wr = 0, a_rd = 0;
  logic [31:0] a_wdata = '0, a_rdata;
  logic [4:0]  a_aeth = 5'd2, a_afth = 5'd14, a_cnt;
  logic        a_rvld, a_full, a_empty, a_aempty, a_afull, a_ovf, a_udf;

  sync_fifo_th #(.FIFO_DEPTH(DA), .DATA_WIDTH(32)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .wr_en(a_wr), .wr_data(a_wdata),
    .rd_en(a_rd), .rd_data(a_rdata), .rd_vld(a_rvld), .full(a_full),
    .empty(a_empty), .aempty_th(a_aeth), .aempty(a_aempty),
    .afull_th(a_afth), .afull(a_afull), .cnt(a_cnt), .ovf(a_ovf), .udf(a_udf)
  );

  // ---------------- DUT B (depth 12) ----------------
  logic        b_clr = 0, b_wr = 0, b_rd = 0;
  logic [31:0] b_wdata = '0, b_rdata;
  logic [3:0]  b_aeth = 4'd3, b_afth = 4'd9, b_cnt;
  logic        b_rvld, b_full, b_empty, b_aempty, b_afull, b_ovf, b_udf;

  sync_fifo_th #(.FIFO_DEPTH(DB), .DATA_WIDTH(32)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .wr_en(b_wr), .wr_data(b_wdata),
    .rd_en(b_rd), .rd_data(b_rdata), .rd_vld(b_rvld), .full(b_full),
    .empty(b_empty), .aempty_th(b_aeth), .aempty(b_aempty),
    .afull_th(b_afth), .afull(b_afull), .cnt(b_cnt), .ovf(b_ovf), .udf(b_udf)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        clr, wr, rd;
    logic [31:0] wdata;
    logic [4:0]  cnt;
    logic        empty, full, aempty, afull, rvld;
    logic [31:0] rdata;
    logic        ovf, udf;
  } vec_t;

  vec_t vt[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string t, input vec_t v);
    chk({t, ".cnt"},    32'(a_cnt),    32'(v.cnt));
    chk({t, ".empty"},  32'(a_empty),  32'(v.empty));
    chk({t, ".full"},   32'(a_full),   32'(v.full));
    chk({t, ".aempty"}, 32'(a_aempty), 32'(v.aempty));
    chk({t, ".afull"},  32'(a_afull),  32'(v.afull));
    chk({t, ".rd_vld"}, 32'(a_rvld),   32'(v.rvld));
    chk({t, ".rd_data"}, a_rdata,      v.rdata);
    chk({t, ".ovf"},    32'(a_ovf),    32'(v.ovf));
    chk({t, ".udf"},    32'(a_udf),    32'(v.udf));
  endtask

  task automatic a_cycle(input logic c, input logic w, input logic [31:0] d, input logic r);
    a_clr = c; a_wr = w; a_wdata = d; a_rd = r;
    tick();
  endtask

  // ---------------- reference model for DUT B ----------------
  logic [31:0] m_q[$];
  logic [31:0] m_rdata;
  logic        m_rvld, m_ovf, m_udf, m_cleared;
  int          m_aeth, m_afth;

  task automatic m_reset();
    m_q.delete();
    m_rdata = '0; m_rvld = 0; m_ovf = 0; m_udf = 0; m_cleared = 1;
  endtask

  task automatic b_step(input logic c, input logic w, input logic [31:0] d, input logic r);
    int sz, diff;
    logic oe, ue;
    b_clr = c; b_wr = w; b_wdata = d; b_rd = r;
    sz = m_q.size();
    if (c) begin
      m_q.delete();
      m_rvld = 0; m_ovf = 0; m_udf = 0; m_cleared = 1;
    end else begin
      oe = w && (sz == DB);
      ue = r && (sz == 0);
      m_rvld = 0;
      if (r && sz > 0) begin
        m_rdata = m_q.pop_front();
        m_rvld  = 1;
      end
      if (w && sz < DB) m_q.push_back(d);
      m_ovf = STICKY ? (m_ovf | oe) : oe;
      m_udf = STICKY ? (m_udf | ue) : ue;
      m_cleared = 0;
    end
    m_aeth = int'(b_aeth);
    m_afth = int'(b_afth);
    tick();
    sz = m_q.size();
    chk("b.cnt",    32'(b_cnt),    32'(sz));
    chk("b.full",   32'(b_full),   32'(sz == DB));
    chk("b.empty",  32'(b_empty),  32'(sz == 0));
    chk("b.aempty", 32'(b_aempty), 32'(m_cleared ? 1'b1 : (sz <= m_aeth)));
    chk("b.afull",  32'(b_afull),  32'(m_cleared ? 1'b0 : (sz >= m_afth)));
    chk("b.rd_vld", 32'(b_rvld),   32'(m_rvld));
    chk("b.rd_data", b_rdata,      m_rdata);
    chk("b.ovf",    32'(b_ovf),    32'(m_ovf));
    chk("b.udf",    32'(b_udf),    32'(m_udf));
    diff = (int'(u_b.wr_ptr_q) - int'(u_b.rd_ptr_q) + DB) % DB;
    chk("b.ptr_inv", 32'(diff), 32'(sz % DB));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    int written, cyc, mode;
    logic w, r;

    // Table: 17 writes (last one overflows) then 17 reads (last underflows).
    for (int i = 0; i < 17; i++) begin
      int c;
      c = (i < 16) ? i + 1 : 16;
      v = '{clr: 0, wr: 1, rd: 0, wdata: 32'h1000 + 32'(i), cnt: 5'(c),
            empty: 0, full: (c == 16), aempty: (c <= 2), afull: (c >= 14),
            rvld: 0, rdata: 32'h0, ovf: (i == 16), udf: 0};
      vt.push_back(v);
    end
    for (int j = 0; j < 17; j++) begin
      int c;
      c = (j < 16) ? 15 - j : 0;
      v = '{clr: 0, wr: 0, rd: 1, wdata: 32'h0, cnt: 5'(c),
            empty: (c == 0), full: 0, aempty: (c <= 2), afull: (c >= 14),
            rvld: (j < 16), rdata: 32'h1000 + 32'((j < 16) ? j : 15),
            ovf: STICKY, udf: (j == 16)};
      vt.push_back(v);
    end

    // Reset
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    a_cycle(0, 0, 0, 0);
    v = '{clr: 0, wr: 0, rd: 0, wdata: 0, cnt: 0, empty: 1, full: 0, aempty: 1,
          afull: 0, rvld: 0, rdata: 0, ovf: 0, udf: 0};
    chk_a("reset", v);

    // Fill / drain table
    for (int k = 0; k < vt.size(); k++) begin
      a_cycle(vt[k].clr, vt[k].wr, vt[k].wdata, vt[k].rd);
      chk_a($sformatf("vec%0d", k), vt[k]);
    end

    // Flush clears error flags, keeps rd_data
    a_cycle(1, 0, 0, 0);
    chk("s1.cnt", 32'(a_cnt), 0);
    chk("s1.ovf", 32'(a_ovf), 0);
    chk("s1.udf", 32'(a_udf), 0);
    chk("s1.rd_data", a_rdata, 32'h100F);

    // Simultaneous read+write at cnt=5
    for (int i = 0; i < 5; i++) begin
      a_cycle(0, 1, 32'h2000 + 32'(i), 0);
      exp_q.push_back(32'h2000 + 32'(i));
    end
    exp_q.push_back(32'h2100);
    a_cycle(0, 1, 32'h2100, 1);
    chk("s2.cnt", 32'(a_cnt), 5);
    chk("s2.rd_vld", 32'(a_rvld), 1);
    chk("s2.rd_data", a_rdata, exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      a_cycle(0, 0, 0, 1);
      chk("s2.order", a_rdata, exp_q.pop_front());
    end
    chk("s2.empty", 32'(a_empty), 1);

    // Simultaneous read+write while full
    for (int i = 0; i < 16; i++) a_cycle(0, 1, 32'h3000 + 32'(i), 0);
    chk("s3.full", 32'(a_full), 1);
    a_cycle(0, 1, 32'h3999, 1);
    chk("s3.cnt", 32'(a_cnt), 15);
    chk("s3.ovf", 32'(a_ovf), 1);
    chk("s3.rd_data", a_rdata, 32'h3000);
    chk("s3.full_after", 32'(a_full), 0);
    a_cycle(1, 0, 0, 0);

    // Simultaneous read+write while empty
    a_cycle(0, 1, 32'h4000, 1);
    chk("s4.cnt", 32'(a_cnt), 1);
    chk("s4.udf", 32'(a_udf), 1);
    chk("s4.rd_vld", 32'(a_rvld), 0);
    a_cycle(0, 0, 0, 1);
    chk("s4.rd_data", a_rdata, 32'h4000);
    chk("s4.udf_after", 32'(a_udf), 32'(STICKY));

    // Flush at cnt=7 with concurrent wr/rd
    for (int i = 0; i < 7; i++) a_cycle(0, 1, 32'h5000 + 32'(i), 0);
    chk("s5.cnt7", 32'(a_cnt), 7);
    a_cycle(1, 1, 32'h5555, 1);
    v = '{clr: 0, wr: 0, rd: 0, wdata: 0, cnt: 0, empty: 1, full: 0, aempty: 1,
          afull: 0, rvld: 0, rdata: 32'h4000, ovf: 0, udf: 0};
    chk_a("s5.flush", v);
    a_cycle(0, 1, 32'h6000, 0);
    a_cycle(0, 0, 0, 1);
    chk("s5.new_data", a_rdata, 32'h6000);
    chk("s5.new_vld", 32'(a_rvld), 1);

    // Threshold edge cases
    a_afth = 5'd0;
    a_cycle(0, 0, 0, 0);
    chk("s6.afull_th0", 32'(a_afull), 1);
    a_aeth = 5'd16; a_afth = 5'd17;
    for (int i = 0; i < 16; i++) a_cycle(0, 1, 32'h7000 + 32'(i), 0);
    chk("s6.full", 32'(a_full), 1);
    chk("s6.aempty_hi", 32'(a_aempty), 1);
    chk("s6.afull_hi", 32'(a_afull), 0);
    a_aeth = 5'd2; a_afth = 5'd14;
    a_cycle(1, 0, 0, 0);
    a_cycle(0, 0, 0, 0);

    // ---------- DUT B: reset, wrap traffic, random traffic ----------
    rst_n = 0;
    b_aeth = 4'd3; b_afth = 4'd9;
    tick(); tick();
    rst_n = 1;
    m_reset();
    b_step(0, 0, 0, 0);

    written = 0;
    cyc = 0;
    while (written < 30 && cyc < 500) begin
      int sz;
      sz = m_q.size();
      w = (sz < 9) && ($urandom_range(0, 3) != 0);
      r = (sz > 3) && ($urandom_range(0, 1) != 0);
      if (w) written++;
      b_step(0, w, $urandom, r);
      cyc++;
    end
    chk("b.wrap_done", 32'(written), 30);
    while (m_q.size() > 0 && cyc < 600) begin
      b_step(0, 0, 0, 1);
      cyc++;
    end

    mode = 0;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) mode = $urandom_range(0, 2);
      if (i % 20 == 0) begin
        b_aeth = 4'($urandom_range(0, 15));
        b_afth = 4'($urandom_range(0, 15));
      end
      case (mode)
        0:       begin w = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0); end
        1:       begin w = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0); end
        default: begin w = $urandom_range(0, 1) != 0;   r = $urandom_range(0, 1) != 0;   end
      endcase
      b_step(($urandom_range(0, 39) == 0), w, $urandom, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
